mux_ulab_pipe: RTL and testbench

//  Parametrised, registered ALU operand-B selector for the datapath.

---
 rtl/mux_ulab_pipe_if.sv | 27 ++
 rtl/mux_ulab_pipe.sv | 111 +++++++++++
 tb/tb_mux_ulab_pipe.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mux_ulab_pipe_if.sv
// Operand-B request/response bundle between decode/register-read and the ALU.
// Carries the upstream request (valid/ready + select fields) and the downstream result.
// master = producer/consumer side around the selector, slave = the selector itself.
interface mux_ulab_pipe_if #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       sel;
  logic [WIDTH-1:0] reg_b;
  logic [IMM_W-1:0] imm;
  logic [4:0]       shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, sel, reg_b, imm, shamt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, sel, reg_b, imm, shamt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mux_ulab_pipe.sv
// Registered ALU operand-B selector feeding a 2-entry skid buffer.
// Latency: 1 cycle from accept to out_data when the buffer is empty or popping.
// Backpressure: absorbs one extra operand while stalled; in_ready drops only when both entries are full.
module mux_ulab_pipe #(
  parameter int WIDTH      = 32,
  parameter int IMM_W      = 16,
  parameter int CONST_STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  mux_ulab_pipe_if.slave  bus,
  output logic            sel_err,
  input  logic            clr_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] skid;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [WIDTH-1:0] sel_val;
  logic [WIDTH-1:0] imm_sext;
  logic             accept;
  logic             pop;

  assign accept        = bus.in_valid && in_ready_q;
  assign pop           = out_valid_q && bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = head;
  assign imm_sext      = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};

  // Operand-B mux; reserved encoding yields zero so the ALU sees a harmless value.
  always_comb begin
    sel_val = '0;
    case (bus.sel)
      3'b000:  sel_val = bus.reg_b;
      3'b001:  sel_val = WIDTH'(CONST_STEP);
      3'b010:  sel_val = imm_sext;
      3'b011:  sel_val = imm_sext << 2;
      3'b100:  sel_val = {{(WIDTH-IMM_W){1'b0}}, bus.imm};
      3'b101:  sel_val = WIDTH'(bus.imm) << 16;
      3'b110:  sel_val = {{(WIDTH-5){1'b0}}, bus.shamt};
      default: sel_val = '0;
    endcase
  end

  // Skid-buffer FSM; handshake outputs are registered so they depend on state only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= EMPTY;
      head        <= '0;
      skid        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head        <= sel_val;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            skid       <= sel_val;
            state      <= TWO;
            in_ready_q <= 1'b0;
          end else if (accept && pop) begin
            head <= sel_val;
          end else if (pop) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            head       <= skid;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Sticky reserved-select flag; a fresh error in the same cycle beats the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_err <= 1'b0;
    end else if (accept && (bus.sel == 3'b111)) begin
      sel_err <= 1'b1;
    end else if (clr_err) begin
      sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_ulab_pipe.sv
// Directed bench for mux_ulab_pipe: select encodings, stall/skid ordering,
// sticky error flag, asynchronous reset in the full state, and streaming throughput.
module tb_mux_ulab_pipe;

  logic clk;
  logic reset;
  logic sel_err;
  logic clr_err;
  int   vectors;
  int   miscompares;

  mux_ulab_pipe_if #(.WIDTH(32), .IMM_W(16)) bus ();

  mux_ulab_pipe #(.WIDTH(32), .IMM_W(16), .CONST_STEP(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .sel_err (sel_err),
    .clr_err (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  sels [7];
    logic [15:0] imms [7];
    logic [31:0] exps [7];

    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b0;
    clr_err      = 1'b0;
    bus.in_valid = 1'b0;
    bus.sel      = 3'b000;
    bus.reg_b    = 32'h0;
    bus.imm      = 16'h0;
    bus.shamt    = 5'h0;
    bus.out_ready = 1'b1;

    // Reset state
    tick();
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    check("rst_out_data",  bus.out_data,           32'h0);
    check("rst_sel_err",   {31'b0, sel_err},       32'd0);
    reset = 1'b1;

    // PC step constant, single request
    bus.sel      = 3'b001;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("step_valid", {31'b0, bus.out_valid}, 32'd1);
    check("step_data",  bus.out_data,           32'd4);
    tick();
    check("step_valid_drop", {31'b0, bus.out_valid}, 32'd0);

    // Select encodings, streamed back-to-back
    sels[0] = 3'b000; imms[0] = 16'h0000; exps[0] = 32'h12345678;
    sels[1] = 3'b010; imms[1] = 16'h8001; exps[1] = 32'hFFFF8001;
    sels[2] = 3'b011; imms[2] = 16'h8001; exps[2] = 32'hFFFE0004;
    sels[3] = 3'b100; imms[3] = 16'h8001; exps[3] = 32'h00008001;
    sels[4] = 3'b101; imms[4] = 16'h8001; exps[4] = 32'h80010000;
    sels[5] = 3'b110; imms[5] = 16'h0000; exps[5] = 32'h0000001F;
    sels[6] = 3'b010; imms[6] = 16'h7FFF; exps[6] = 32'h00007FFF;
    bus.reg_b = 32'h12345678;
    bus.shamt = 5'h1F;
    for (int i = 0; i < 7; i++) begin
      bus.sel      = sels[i];
      bus.imm      = imms[i];
      bus.in_valid = 1'b1;
      tick();
      check($sformatf("sel_%0d_data", i), bus.out_data, exps[i]);
      check($sformatf("sel_%0d_valid", i), {31'b0, bus.out_valid}, 32'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("sel_idle_valid", {31'b0, bus.out_valid}, 32'd0);

    // Stall: A, B accepted, C refused, then drained in order
    bus.sel       = 3'b000;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.reg_b     = 32'hAAAA0001;
    tick();
    check("stall_a_data",  bus.out_data,          32'hAAAA0001);
    check("stall_a_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.reg_b = 32'hBBBB0002;
    tick();
    check("stall_b_ready", {31'b0, bus.in_ready}, 32'd0);
    check("stall_b_head",  bus.out_data,          32'hAAAA0001);
    bus.reg_b = 32'hCCCC0003;
    tick();
    check("stall_c_ready", {31'b0, bus.in_ready}, 32'd0);
    check("stall_hold1",   bus.out_data,          32'hAAAA0001);
    tick();
    check("stall_hold2",   bus.out_data,          32'hAAAA0001);
    check("stall_valid",   {31'b0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    check("drain_b",       bus.out_data,          32'hBBBB0002);
    check("drain_b_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    check("drain_c",       bus.out_data,          32'hCCCC0003);
    bus.in_valid = 1'b0;
    tick();
    check("drain_empty",   {31'b0, bus.out_valid}, 32'd0);

    // Reserved select and sticky error flag
    bus.sel      = 3'b111;
    bus.reg_b    = 32'hDEADBEEF;
    bus.in_valid = 1'b1;
    tick();
    check("rsv_data",    bus.out_data,     32'h0);
    check("rsv_err_set", {31'b0, sel_err}, 32'd1);
    bus.in_valid = 1'b0;
    tick();
    check("rsv_err_sticky", {31'b0, sel_err}, 32'd1);
    bus.in_valid = 1'b1;
    clr_err      = 1'b1;
    tick();
    check("rsv_set_beats_clr", {31'b0, sel_err}, 32'd1);
    bus.in_valid = 1'b0;
    tick();
    check("rsv_clr", {31'b0, sel_err}, 32'd0);
    clr_err = 1'b0;
    tick();

    // Fill to TWO, then reset asynchronously mid-cycle
    bus.sel       = 3'b000;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.reg_b     = 32'h0D0D0001;
    tick();
    bus.reg_b = 32'h0D0D0002;
    tick();
    check("full_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("arst_ready", {31'b0, bus.in_ready},  32'd1);
    check("arst_data",  bus.out_data,           32'h0);
    #2;
    reset = 1'b1;
    tick();
    check("post_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.reg_b     = 32'h00000055;
    tick();
    check("post_rst_data", bus.out_data, 32'h00000055);
    bus.in_valid = 1'b0;
    tick();
    check("post_rst_no_stale", {31'b0, bus.out_valid}, 32'd0);

    // Continuous streaming: one result per cycle, no bubbles
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.reg_b = 32'd100 + 32'(i);
      tick();
      check($sformatf("stream_%0d_data", i), bus.out_data, 32'd100 + 32'(i));
      check($sformatf("stream_%0d_valid", i), {31'b0, bus.out_valid}, 32'd1);
      check($sformatf("stream_%0d_ready", i), {31'b0, bus.in_ready}, 32'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_end", {31'b0, bus.out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
